// File: rtl/call_stack_pkg.sv
// Shared constants and types for the return-address stack: overflow policies
// (also decoded by the Controller) and the push/pop operation encoding.
package call_stack_pkg;

   localparam int OVF_SATURATE = 0;
   localparam int OVF_WRAP     = 1;

   typedef enum logic [1:0] {
      OP_IDLE    = 2'b00,
      OP_POP     = 2'b01,
      OP_PUSH    = 2'b10,
      OP_REPLACE = 2'b11
   } stack_op_e;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/call_stack_if.sv
// Handshake/data bundle between the datapath (master) and the call stack (slave).
interface call_stack_if #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
);
   import call_stack_pkg::*;

   localparam int CW = count_width(DEPTH);

   logic             push;
   logic             pop;
   logic             flush;
   logic             clr_err;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] top_data;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             stack_overflow;
   logic             stack_underflow;

   modport master (
      output push, pop, flush, clr_err, push_data,
      input  top_data, count, empty, full, stack_overflow, stack_underflow
   );

   modport slave (
      input  push, pop, flush, clr_err, push_data,
      output top_data, count, empty, full, stack_overflow, stack_underflow
   );

endinterface

// File: rtl/call_stack_ptr.sv
// Top-pointer and occupancy bookkeeping for the circular call stack, plus the
// sticky error flags and the storage write strobe/index.
module call_stack_ptr
   import call_stack_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int OVF_MODE = OVF_SATURATE,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = count_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic          clr_err,
   output logic [PW-1:0] tp,
   output logic [CW-1:0] count,
   output logic          stack_overflow,
   output logic          stack_underflow,
   output logic          wr_en,
   output logic [PW-1:0] wr_idx
);

   stack_op_e     op;
   logic [PW-1:0] tp_inc;
   logic [PW-1:0] tp_dec;
   logic [PW-1:0] tp_next;
   logic [CW-1:0] count_next;
   logic          is_empty;
   logic          is_full;
   logic          ovf_set;
   logic          unf_set;

   assign op       = stack_op_e'({push, pop});
   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(DEPTH));

   // Explicit wrap so non-power-of-two depths stay in range
   assign tp_inc = (tp == PW'(DEPTH - 1)) ? '0 : tp + 1'b1;
   assign tp_dec = (tp == '0) ? PW'(DEPTH - 1) : tp - 1'b1;

   always_comb begin
      tp_next    = tp;
      count_next = count;
      wr_en      = 1'b0;
      wr_idx     = tp;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      if (flush) begin
         count_next = '0;
      end else begin
         case (op)
            OP_IDLE: ;
            OP_PUSH: begin
               if (!is_full) begin
                  tp_next    = is_empty ? tp : tp_inc;
                  wr_idx     = tp_next;
                  wr_en      = 1'b1;
                  count_next = count + 1'b1;
               end else begin
                  ovf_set = 1'b1;
                  if (OVF_MODE == OVF_WRAP) begin
                     tp_next = tp_inc;
                     wr_idx  = tp_inc;
                     wr_en   = 1'b1;
                  end
               end
            end
            OP_POP: begin
               if (!is_empty) begin
                  count_next = count - 1'b1;
                  if (count != CW'(1)) tp_next = tp_dec;
               end else begin
                  unf_set = 1'b1;
               end
            end
            OP_REPLACE: begin
               // On an empty stack the pop half is an error but the push still lands
               wr_en = 1'b1;
               if (is_empty) begin
                  unf_set    = 1'b1;
                  count_next = CW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tp              <= '0;
         count           <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         tp              <= tp_next;
         count           <= count_next;
         stack_overflow  <= ovf_set | (stack_overflow & ~clr_err);
         stack_underflow <= unf_set | (stack_underflow & ~clr_err);
      end
   end

endmodule

// File: rtl/call_stack.sv
// Parametrised return-address/data stack; top entry is readable combinationally
// so a return can consume it in the same cycle it pops.
module call_stack
   import call_stack_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int DEPTH    = 8,
   parameter int OVF_MODE = OVF_SATURATE
) (
   input logic         clk,
   input logic         rst,
   call_stack_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    tp;
   logic [PW-1:0]    wr_idx;
   logic [CW-1:0]    count;
   logic             wr_en;

   call_stack_ptr #(
      .DEPTH    (DEPTH),
      .OVF_MODE (OVF_MODE)
   ) u_ptr (
      .clk             (clk),
      .rst             (rst),
      .push            (bus.push),
      .pop             (bus.pop),
      .flush           (bus.flush),
      .clr_err         (bus.clr_err),
      .tp              (tp),
      .count           (count),
      .stack_overflow  (bus.stack_overflow),
      .stack_underflow (bus.stack_underflow),
      .wr_en           (wr_en),
      .wr_idx          (wr_idx)
   );

   // Storage is deliberately not reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_idx] <= bus.push_data;
   end

   assign bus.top_data = (count != '0) ? mem[tp] : '0;
   assign bus.count    = count;
   assign bus.empty    = (count == '0);
   assign bus.full     = (count == CW'(DEPTH));

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench: a saturating and a wrapping DEPTH=4 stack driven in lockstep
// against a queue-based reference model, plus a directed vector table.
module tb_call_stack;
   import call_stack_pkg::*;

   localparam int W  = 12;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   call_stack_if #(.WIDTH(W), .DEPTH(D)) bus_sat ();
   call_stack_if #(.WIDTH(W), .DEPTH(D)) bus_wrap ();

   call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(OVF_SATURATE)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat.slave)
   );

   call_stack #(.WIDTH(W), .DEPTH(D), .OVF_MODE(OVF_WRAP)) dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bus_wrap.slave)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: back of queue is the top of stack
   logic [W-1:0] q_sat[$];
   logic [W-1:0] q_wrap[$];
   bit           m_ovf;
   bit           m_unf;

   typedef struct {
      bit           pu;
      bit           po;
      bit           fl;
      bit           ce;
      logic [W-1:0] d;
      logic [W-1:0] top;
      int           cnt;
      bit           ovf;
      bit           unf;
   } vec_t;

   vec_t         vecs[16];
   logic [W-1:0] pops_sat [4];
   logic [W-1:0] pops_wrap[4];

   task automatic model_reset();
      q_sat.delete();
      q_wrap.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input bit pu, input bit po, input bit fl, input bit ce,
                             input logic [W-1:0] d);
      int n;
      bit ov;
      bit un;
      n  = q_sat.size();
      ov = 1'b0;
      un = 1'b0;
      if (fl) begin
         q_sat.delete();
         q_wrap.delete();
      end else if (pu && po) begin
         if (n == 0) begin
            un = 1'b1;
            q_sat.push_back(d);
            q_wrap.push_back(d);
         end else begin
            q_sat[n-1]  = d;
            q_wrap[n-1] = d;
         end
      end else if (pu) begin
         if (n < D) begin
            q_sat.push_back(d);
            q_wrap.push_back(d);
         end else begin
            ov = 1'b1;
            void'(q_wrap.pop_front());
            q_wrap.push_back(d);
         end
      end else if (po) begin
         if (n == 0) un = 1'b1;
         else begin
            void'(q_sat.pop_back());
            void'(q_wrap.pop_back());
         end
      end
      m_ovf = ov | (m_ovf & ~ce);
      m_unf = un | (m_unf & ~ce);
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      logic [W-1:0] ts;
      logic [W-1:0] tw;
      n  = q_sat.size();
      ts = (n > 0) ? q_sat[n-1] : '0;
      tw = (n > 0) ? q_wrap[n-1] : '0;
      check_val({tag, " sat top"},   32'(bus_sat.top_data),        32'(ts));
      check_val({tag, " sat count"}, 32'(bus_sat.count),           32'(n));
      check_val({tag, " sat empty"}, 32'(bus_sat.empty),           32'(n == 0));
      check_val({tag, " sat full"},  32'(bus_sat.full),            32'(n == D));
      check_val({tag, " sat ovf"},   32'(bus_sat.stack_overflow),  32'(m_ovf));
      check_val({tag, " sat unf"},   32'(bus_sat.stack_underflow), 32'(m_unf));
      check_val({tag, " wrap top"},  32'(bus_wrap.top_data),       32'(tw));
      check_val({tag, " wrap count"},32'(bus_wrap.count),          32'(n));
      check_val({tag, " wrap ovf"},  32'(bus_wrap.stack_overflow), 32'(m_ovf));
      check_val({tag, " wrap unf"},  32'(bus_wrap.stack_underflow),32'(m_unf));
   endtask

   task automatic drive(input bit pu, input bit po, input bit fl, input bit ce,
                        input logic [W-1:0] d);
      bus_sat.push       = pu;
      bus_sat.pop        = po;
      bus_sat.flush      = fl;
      bus_sat.clr_err    = ce;
      bus_sat.push_data  = d;
      bus_wrap.push      = pu;
      bus_wrap.pop       = po;
      bus_wrap.flush     = fl;
      bus_wrap.clr_err   = ce;
      bus_wrap.push_data = d;
   endtask

   // One clock of stimulus; returns 1 time unit after the edge with the model updated
   task automatic apply_stimulus(input bit pu, input bit po, input bit fl, input bit ce,
                                 input logic [W-1:0] d);
      drive(pu, po, fl, ce, d);
      @(posedge clk);
      model_step(pu, po, fl, ce, d);
      #1;
   endtask

   initial begin
      //            pu po fl ce data     top     cnt ovf unf
      vecs[0]  = '{1, 0, 0, 0, 12'h001, 12'h001, 1, 0, 0};
      vecs[1]  = '{1, 0, 0, 0, 12'h002, 12'h002, 2, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 12'h003, 12'h003, 3, 0, 0};
      vecs[3]  = '{1, 0, 0, 0, 12'h004, 12'h004, 4, 0, 0};
      vecs[4]  = '{1, 0, 0, 0, 12'h0AA, 12'h004, 4, 1, 0};
      vecs[5]  = '{0, 1, 0, 0, 12'h000, 12'h003, 3, 1, 0};
      vecs[6]  = '{1, 1, 0, 0, 12'h0FF, 12'h0FF, 3, 1, 0};
      vecs[7]  = '{0, 0, 0, 1, 12'h000, 12'h0FF, 3, 0, 0};
      vecs[8]  = '{1, 0, 1, 0, 12'h123, 12'h000, 0, 0, 0};
      vecs[9]  = '{0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 1};
      vecs[10] = '{0, 1, 0, 1, 12'h000, 12'h000, 0, 0, 1};
      vecs[11] = '{0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0};
      vecs[12] = '{1, 1, 0, 0, 12'h055, 12'h055, 1, 0, 1};
      vecs[13] = '{1, 0, 0, 0, 12'h066, 12'h066, 2, 0, 1};
      vecs[14] = '{0, 1, 0, 0, 12'h000, 12'h055, 1, 0, 1};
      vecs[15] = '{0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 1};

      pops_sat  = '{12'h004, 12'h003, 12'h002, 12'h001};
      pops_wrap = '{12'h0AA, 12'h004, 12'h003, 12'h002};

      rst = 1'b1;
      drive(0, 0, 0, 0, '0);
      model_reset();
      #12;
      check_model("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].ce, vecs[i].d);
         check_val($sformatf("vec%0d top", i),   32'(bus_sat.top_data),        32'(vecs[i].top));
         check_val($sformatf("vec%0d count", i), 32'(bus_sat.count),           32'(vecs[i].cnt));
         check_val($sformatf("vec%0d empty", i), 32'(bus_sat.empty),           32'(vecs[i].cnt == 0));
         check_val($sformatf("vec%0d full", i),  32'(bus_sat.full),            32'(vecs[i].cnt == D));
         check_val($sformatf("vec%0d ovf", i),   32'(bus_sat.stack_overflow),  32'(vecs[i].ovf));
         check_val($sformatf("vec%0d unf", i),   32'(bus_sat.stack_underflow), 32'(vecs[i].unf));
      end

      // Asynchronous reset between edges must clear state without waiting for a clock
      apply_stimulus(1, 0, 0, 0, 12'h111);
      apply_stimulus(1, 0, 0, 0, 12'h222);
      check_val("pre-reset top", 32'(bus_sat.top_data), 32'h222);
      drive(0, 0, 0, 0, '0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_model("mid-run reset");
      @(negedge clk);
      rst = 1'b0;

      // Overflow policy: saturate drops the push, wrap overwrites the oldest entry
      for (int i = 1; i <= 4; i++) apply_stimulus(1, 0, 0, 0, W'(i));
      apply_stimulus(1, 0, 0, 0, 12'h0AA);
      check_model("overflow");
      check_val("wrap top after ovf", 32'(bus_wrap.top_data), 32'h0AA);
      check_val("sat top after ovf",  32'(bus_sat.top_data),  32'h004);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("sat pop%0d", i),  32'(bus_sat.top_data),  32'(pops_sat[i]));
         check_val($sformatf("wrap pop%0d", i), 32'(bus_wrap.top_data), 32'(pops_wrap[i]));
         apply_stimulus(0, 1, 0, 0, '0);
      end
      check_model("drained");

      // Randomised traffic against the queue model
      apply_stimulus(0, 0, 0, 1, '0);
      for (int i = 0; i < 400; i++) begin
         apply_stimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                        $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                        W'($urandom));
         check_model($sformatf("rand%0d", i));
      end

      drive(0, 0, 0, 0, '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
